// File: rtl/sat_job_sequencer_pkg.sv
// Shared types for the SAT job sequencer: clause word layout and controller states.
package sat_job_sequencer_pkg;

  localparam int NUMBER_LITERAL = 5;

  typedef struct packed {
    logic [NUMBER_LITERAL-1:0] pos;
    logic [NUMBER_LITERAL-1:0] neg;
  } clause_t;

  typedef enum logic [2:0] {
    IDLE,
    SRST,
    POS,
    NEG,
    PAD,
    WAIT,
    DONE
  } seq_state_t;

endpackage

// File: rtl/sat_job_sequencer_clause_buffer.sv
// Clause register file for the job sequencer: append-only write port with a
// live-entry count and a combinational indexed read port.
module sat_job_sequencer_clause_buffer
  import sat_job_sequencer_pkg::*;
#(
  parameter int MAX_CLAUSES = 16,
  localparam int CW = $clog2(MAX_CLAUSES + 1),
  localparam int AW = (MAX_CLAUSES > 1) ? $clog2(MAX_CLAUSES) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clr,
  input  logic          wr_en,
  input  clause_t       wr_data,
  input  logic [AW-1:0] rd_idx,
  output clause_t       rd_data,
  output logic [CW-1:0] count
);

  clause_t       mem [MAX_CLAUSES];
  logic [CW-1:0] count_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (wr_en) begin
      count_q <= count_q + 1'b1;
    end
  end

  // NOTE: the array has no reset; the count alone decides which entries are
  // live, so stale contents are never read.
  always_ff @(posedge clock) begin
    if (wr_en && !clr) begin
      mem[count_q[AW-1:0]] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];
  assign count   = count_q;

endmodule

// File: rtl/sat_job_sequencer.sv
// Front-end job controller for the SAT solver core: buffers clauses, streams them
// as pos/neg word pairs plus zero padding, then waits for the verdict with a timeout.
// Build option: define TAUT_FILTER_EN to silently discard clauses with (pos & neg) != 0.
module sat_job_sequencer
  import sat_job_sequencer_pkg::*;
#(
  parameter int MAX_CLAUSES    = 16,
  parameter int PAD_PAIRS      = 1,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int CW = $clog2(MAX_CLAUSES + 1),
  localparam int AW = (MAX_CLAUSES > 1) ? $clog2(MAX_CLAUSES) : 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      cl_valid,
  output logic                      cl_ready,
  input  logic [NUMBER_LITERAL-1:0] cl_pos,
  input  logic [NUMBER_LITERAL-1:0] cl_neg,
  input  logic                      start,
  input  logic                      clear,
  output logic                      busy,
  output logic                      done,
  output logic                      result_sat,
  output logic [NUMBER_LITERAL-1:0] result_model,
  output logic                      timeout,
  output logic [CW-1:0]             clause_count,
  output logic                      drop_err,
  output logic                      solver_reset,
  output logic                      solver_load,
  output logic [NUMBER_LITERAL-1:0] solver_i,
  input  logic                      solver_ended,
  input  logic                      solver_sat,
  input  logic [NUMBER_LITERAL-1:0] solver_model
);

  localparam logic [CW-1:0] MAX_CNT    = CW'(MAX_CLAUSES);
  localparam int            PW         = $clog2(2 * PAD_PAIRS + 1);
  localparam logic [PW-1:0] PAD_LAST   = PW'(2 * PAD_PAIRS - 1);
  localparam int            TW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  seq_state_t                state, state_n;
  logic [AW-1:0]             idx, idx_n;
  logic [PW-1:0]             pad_cnt, pad_cnt_n;
  logic [TW-1:0]             timer, timer_n;
  logic                      busy_n, done_n, sat_n, timeout_n, drop_n, srst_n, load_n;
  logic [NUMBER_LITERAL-1:0] model_n, word_n;
  clause_t                   in_clause, rd_clause;
  logic                      accept, empty_clause, keep, last_clause;

  assign in_clause    = '{pos: cl_pos, neg: cl_neg};
  assign cl_ready     = (state == IDLE) && (clause_count < MAX_CNT);
  assign accept       = cl_valid && cl_ready;
  assign empty_clause = (cl_pos == '0) && (cl_neg == '0);
  assign last_clause  = (CW'(idx) + 1'b1) == clause_count;

`ifdef TAUT_FILTER_EN
  assign keep = accept && !empty_clause && ((cl_pos & cl_neg) == '0);
`else
  assign keep = accept && !empty_clause;
`endif

  sat_job_sequencer_clause_buffer #(
    .MAX_CLAUSES(MAX_CLAUSES)
  ) u_buffer (
    .clock  (clock),
    .reset  (reset),
    .clr    (clear),
    .wr_en  (keep),
    .wr_data(in_clause),
    .rd_idx (idx_n),
    .rd_data(rd_clause),
    .count  (clause_count)
  );

  // NOTE: every *_n signal is given its held value before the case, so no
  // path through this block can infer a latch.
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    pad_cnt_n = pad_cnt;
    timer_n   = timer;
    busy_n    = busy;
    done_n    = done;
    sat_n     = result_sat;
    model_n   = result_model;
    timeout_n = timeout;
    drop_n    = drop_err;
    srst_n    = solver_reset;

    if (clear) begin
      state_n   = IDLE;
      busy_n    = 1'b0;
      done_n    = 1'b0;
      sat_n     = 1'b0;
      model_n   = '0;
      timeout_n = 1'b0;
      drop_n    = 1'b0;
      srst_n    = 1'b1;
    end else begin
      if (accept && empty_clause) drop_n = 1'b1;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            timeout_n = 1'b0;
            if (clause_count == '0) begin
              state_n = DONE;
              done_n  = 1'b1;
              sat_n   = 1'b1;
              model_n = '0;
            end else begin
              state_n = SRST;
              done_n  = 1'b0;
              busy_n  = 1'b1;
              srst_n  = 1'b1;
              idx_n   = '0;
            end
          end
        end
        SRST: begin
          state_n = POS;
          srst_n  = 1'b0;
        end
        POS: state_n = NEG;
        NEG: begin
          if (last_clause) begin
            state_n   = PAD;
            pad_cnt_n = '0;
          end else begin
            state_n = POS;
            idx_n   = idx + 1'b1;
          end
        end
        PAD: begin
          if (pad_cnt == PAD_LAST) begin
            state_n = WAIT;
            timer_n = '0;
          end else begin
            pad_cnt_n = pad_cnt + 1'b1;
          end
        end
        WAIT: begin
          if (solver_ended) begin
            state_n = DONE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            sat_n   = solver_sat;
            model_n = solver_model;
          end else if (timer == TIMER_LAST) begin
            state_n   = DONE;
            busy_n    = 1'b0;
            done_n    = 1'b1;
            sat_n     = 1'b0;
            timeout_n = 1'b1;
          end else begin
            timer_n = timer + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Solver-facing outputs are registered from the next state, so the word
  // appears in the same cycle the FSM enters POS/NEG/PAD.
  always_comb begin
    word_n = '0;
    if (state_n == POS) begin
      word_n = rd_clause.pos;
    end else if (state_n == NEG) begin
      word_n = rd_clause.neg;
    end
  end

  assign load_n = (state_n == POS) || (state_n == NEG) || (state_n == PAD);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      idx          <= '0;
      pad_cnt      <= '0;
      timer        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result_sat   <= 1'b0;
      result_model <= '0;
      timeout      <= 1'b0;
      drop_err     <= 1'b0;
      solver_reset <= 1'b1;
      solver_load  <= 1'b0;
      solver_i     <= '0;
    end else begin
      state        <= state_n;
      idx          <= idx_n;
      pad_cnt      <= pad_cnt_n;
      timer        <= timer_n;
      busy         <= busy_n;
      done         <= done_n;
      result_sat   <= sat_n;
      result_model <= model_n;
      timeout      <= timeout_n;
      drop_err     <= drop_n;
      solver_reset <= srst_n;
      solver_load  <= load_n;
      solver_i     <= word_n;
    end
  end

endmodule

// File: tb/tb_sat_job_sequencer.sv
// Scoreboard bench for sat_job_sequencer: a clause-list model predicts the solver
// word stream and captured result; a forked monitor compares whenever the DUT presents them.
module tb_sat_job_sequencer;
  import sat_job_sequencer_pkg::*;

  localparam int MAXC = 16;
  localparam int PADP = 1;
  localparam int TOUT = 4096;
  localparam int NL   = NUMBER_LITERAL;
  localparam int CW   = $clog2(MAXC + 1);

  typedef struct packed {
    logic          sat;
    logic [NL-1:0] model;
    logic          tmo;
  } result_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          cl_valid, cl_ready, start, clear;
  logic [NL-1:0] cl_pos, cl_neg;
  logic          busy, done, result_sat, timeout, drop_err;
  logic [NL-1:0] result_model;
  logic [CW-1:0] clause_count;
  logic          solver_reset, solver_load, solver_ended, solver_sat;
  logic [NL-1:0] solver_i, solver_model;

  sat_job_sequencer #(
    .MAX_CLAUSES   (MAXC),
    .PAD_PAIRS     (PADP),
    .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .clock(clock), .reset(reset),
    .cl_valid(cl_valid), .cl_ready(cl_ready), .cl_pos(cl_pos), .cl_neg(cl_neg),
    .start(start), .clear(clear), .busy(busy), .done(done),
    .result_sat(result_sat), .result_model(result_model), .timeout(timeout),
    .clause_count(clause_count), .drop_err(drop_err),
    .solver_reset(solver_reset), .solver_load(solver_load), .solver_i(solver_i),
    .solver_ended(solver_ended), .solver_sat(solver_sat), .solver_model(solver_model)
  );

  initial forever #5 clock = ~clock;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int            n_checks = 0;
  int            n_pass   = 0;
  clause_t       model_q[$];
  bit            drop_exp;
  logic [NL-1:0] model_reg_exp;
  logic [NL-1:0] exp_words[$];
  result_t       exp_results[$];
  logic [NL-1:0] dir_pos [7];
  logic [NL-1:0] dir_neg [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // A clause is satisfied if a positive literal is 1 or a negative literal is 0.
  function automatic bit satisfied_by(input logic [NL-1:0] m);
    foreach (model_q[k])
      if (((m & model_q[k].pos) == '0) && ((~m & model_q[k].neg) == '0)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic monitor();
    logic    done_q = 1'b0;
    result_t r;
    forever begin
      @(negedge clock);
      if (solver_load) begin
        if (exp_words.size() == 0) check("solver_load_idle", solver_load, 1'b0);
        else check("solver_i", solver_i, exp_words.pop_front());
      end
      if (done && !done_q) begin
        check("stream_words_left", exp_words.size(), 0);
        if (exp_results.size() == 0) begin
          check("done_rise_unexpected", done, 1'b0);
        end else begin
          r = exp_results.pop_front();
          check("result_sat", result_sat, r.sat);
          check("result_model", result_model, r.model);
          check("timeout", timeout, r.tmo);
        end
      end
      done_q = done;
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sat", result_sat, 0);
    check("rst_model", result_model, 0);
    check("rst_timeout", timeout, 0);
    check("rst_drop", drop_err, 0);
    check("rst_solver_reset", solver_reset, 1);
    check("rst_load", solver_load, 0);
    check("rst_solver_i", solver_i, 0);
    check("rst_count", clause_count, 0);
  endtask

  task automatic model_clear();
    model_q.delete();
    drop_exp      = 1'b0;
    model_reg_exp = '0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    model_clear();
    check("clear_done", done, 0);
    check("clear_count", clause_count, 0);
    check("clear_drop", drop_err, 0);
    check("clear_model", result_model, 0);
    check("clear_solver_reset", solver_reset, 1);
  endtask

  task automatic offer(input logic [NL-1:0] p, input logic [NL-1:0] n);
    bit took, filtered;
    filtered = 1'b0;
`ifdef TAUT_FILTER_EN
    filtered = (p & n) != '0;
`endif
    cl_valid = 1'b1;
    cl_pos   = p;
    cl_neg   = n;
    check("cl_ready", cl_ready, model_q.size() < MAXC);
    took = cl_ready;
    @(negedge clock);
    cl_valid = 1'b0;
    if (took) begin
      if (p == '0 && n == '0) drop_exp = 1'b1;
      else if (!filtered) model_q.push_back('{pos: p, neg: n});
    end
    check("clause_count", clause_count, model_q.size());
    check("drop_err", drop_err, drop_exp);
  endtask

  task automatic push_stream();
    foreach (model_q[k]) begin
      exp_words.push_back(model_q[k].pos);
      exp_words.push_back(model_q[k].neg);
    end
    if (model_q.size() > 0) repeat (2 * PADP) exp_words.push_back('0);
  endtask

  task automatic run_job(input bit respond, input bit junk);
    result_t       r;
    logic [NL-1:0] stub_model;
    bit            found;
    int            n_load, budget;
    int            nc = model_q.size();
    push_stream();
    found      = 1'b0;
    stub_model = NL'($urandom);
    for (int v = 0; v < (1 << NL) && !found; v++)
      if (satisfied_by(NL'(v))) begin
        found      = 1'b1;
        stub_model = NL'(v);
      end
    if (nc == 0) begin
      r = '{1'b1, '0, 1'b0};
      model_reg_exp = '0;
    end else if (respond) begin
      r = '{found, stub_model, 1'b0};
      model_reg_exp = stub_model;
    end else begin
      r = '{1'b0, model_reg_exp, 1'b1};
    end
    exp_results.push_back(r);

    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    if (nc == 0) begin
      check("empty_done_next", done, 1);
      check("empty_busy", busy, 0);
      @(negedge clock);
      return;
    end
    check("srst_busy", busy, 1);
    check("srst_solver_reset", solver_reset, 1);
    check("srst_load", solver_load, 0);
    if (junk) begin
      solver_ended = 1'b1;
      solver_sat   = 1'($urandom);
      solver_model = NL'($urandom);
    end
    @(negedge clock);
    check("first_load_latency", solver_load, 1);
    check("stream_solver_reset", solver_reset, 0);
    n_load = 0;
    budget = 4 * MAXC + 4 * PADP + 8;
    while (solver_load && budget > 0) begin
      n_load++;
      budget--;
      @(negedge clock);
    end
    check("load_cycles", n_load, 2 * nc + 2 * PADP);
    solver_ended = 1'b0;

    if (respond) begin
      repeat ($urandom_range(0, 20)) @(negedge clock);
      solver_ended = 1'b1;
      solver_sat   = found;
      solver_model = stub_model;
      @(negedge clock);
      solver_ended = 1'b0;
    end else begin
      repeat (TOUT - 1) @(negedge clock);
      check("done_before_timeout", done, 0);
      @(negedge clock);
      check("timeout_at_limit", done, 1);
    end
    budget = 64;
    while (!done && budget > 0) begin
      budget--;
      @(negedge clock);
    end
    check("job_done", done, 1);
    check("done_not_busy", busy, 0);
    check("ready_in_done", cl_ready, 0);
    @(negedge clock);
  endtask

  initial begin
    logic [NL-1:0] p, n;
    int            nc, sel, cnt, budget;

    dir_pos = '{5'b11100, 5'b00000, 5'b00001, 5'b00010, 5'b01100, 5'b11011, 5'b01010};
    dir_neg = '{5'b00000, 5'b11100, 5'b00010, 5'b10000, 5'b00000, 5'b00100, 5'b00001};
    reset = 1'b0; cl_valid = 1'b0; cl_pos = '0; cl_neg = '0;
    start = 1'b0; clear = 1'b0;
    solver_ended = 1'b0; solver_sat = 1'b0; solver_model = '0;
    model_clear();
    fork
      monitor();
    join_none

    repeat (3) @(negedge clock);
    check_reset_outputs();
    reset = 1'b1;
    @(negedge clock);
    check("idle_ready", cl_ready, 1);

    for (int k = 0; k < 7; k++) offer(dir_pos[k], dir_neg[k]);
    run_job(1'b1, 1'b0);
    check("directed_sat", result_sat, 1);
    check("directed_model_ok", satisfied_by(result_model), 1);
    run_job(1'b1, 1'b1);
    run_job(1'b0, 1'b0);
    check("timeout_flag", timeout, 1);

    do_clear();
    run_job(1'b1, 1'b0);
    check("empty_model", result_model, 0);

    do_clear();
    offer('0, '0);
    for (int k = 0; k < MAXC + 1; k++) begin
      p = NL'($urandom_range(1, (1 << NL) - 1));
      offer(p, NL'($urandom) & ~p);
    end
    check("full_count", clause_count, MAXC);
    check("full_ready", cl_ready, 0);
    run_job(1'b1, 1'b1);

    do_clear();
    offer(5'b10000, 5'b10000);
    offer(5'b00110, 5'b00001);
    run_job(1'b1, 1'b0);

    for (int it = 0; it < 6; it++) begin
      do_clear();
      nc = $urandom_range(0, MAXC + 2);
      for (int k = 0; k < nc; k++) begin
        sel = $urandom_range(0, 7);
        p   = NL'($urandom);
        n   = NL'($urandom);
        if (sel == 0) begin
          p = '0;
          n = '0;
        end else if (sel == 1) begin
          p = NL'($urandom_range(1, (1 << NL) - 1));
          n = n | p;
        end
        offer(p, n);
      end
      run_job(1'b1, 1'($urandom));
    end

    do_clear();
    for (int k = 0; k < 7; k++) offer(dir_pos[k], dir_neg[k]);
    push_stream();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cnt    = 0;
    budget = 32;
    while (cnt < 6 && budget > 0) begin
      @(negedge clock);
      if (solver_load) cnt++;
      budget--;
    end
    check("reached_neg_clause3", cnt, 6);
    #1 reset = 1'b0;
    #1;
    check_reset_outputs();
    exp_words.delete();
    model_clear();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    offer(5'b10001, 5'b00100);
    offer(5'b00000, 5'b01010);
    run_job(1'b1, 1'b0);
    start = 1'b1;
    clear = 1'b1;
    @(negedge clock);
    start = 1'b0;
    clear = 1'b0;
    model_clear();
    check("sc_done", done, 0);
    check("sc_busy", busy, 0);
    check("sc_count", clause_count, 0);
    check("sc_ready", cl_ready, 1);
    repeat (4) @(negedge clock);
    check("sc_no_load", solver_load, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
